// File: rtl/isqrt_sum_distributor.sv
// Sums isqrt(arg[i]) over N_ARGS arguments by spreading them round-robin over N_UNITS
// external pipelined isqrt units and accumulating the results as they return.
module isqrt_sum_distributor #(
    parameter int N_ARGS  = 3,
    parameter int N_UNITS = 2,
    parameter int W       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arg_vld,
    output logic                       arg_rdy,
    input  logic [N_ARGS*W-1:0]        args,
    output logic                       res_vld,
    output logic [W-1:0]               res,
    output logic [N_UNITS-1:0]         isqrt_x_vld,
    output logic [N_UNITS*W-1:0]       isqrt_x,
    input  logic [N_UNITS-1:0]         isqrt_y_vld,
    input  logic [N_UNITS*(W/2)-1:0]   isqrt_y
);

    localparam int ROUNDS = (N_ARGS + N_UNITS - 1) / N_UNITS;
    localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int CW     = $clog2(N_ARGS + N_UNITS + 1);
    localparam int HW     = W / 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          state_q;
    logic [RW-1:0]   round_q;
    logic [CW-1:0]   count_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    res_q;
    logic            res_vld_q;

    logic            accept;
    logic            issuing;
    logic [RW-1:0]   rsel;
    logic [W-1:0]    y_sum;
    logic [CW-1:0]   y_cnt;
    logic [CW-1:0]   count_sum;
    logic            done;

    assign arg_rdy = (state_q == S_IDLE) & ~rst;
    assign accept  = arg_vld & arg_rdy;
    assign issuing = accept | (state_q == S_ISSUE);
    // Round 0 goes out in the accept cycle straight from args; later rounds use round_q.
    assign rsel    = (state_q == S_ISSUE) ? round_q : '0;

    genvar gi, gr;
    generate
        for (gi = 0; gi < N_UNITS; gi++) begin : g_unit
            logic [W-1:0]      opnd [ROUNDS];
            logic [ROUNDS-1:0] live;

            for (gr = 0; gr < ROUNDS; gr++) begin : g_round
                if (gr * N_UNITS + gi < N_ARGS) begin : g_live
                    assign live[gr] = 1'b1;
                    if (gr == 0) begin : g_direct
                        assign opnd[gr] = args[gi*W +: W];
                    end else begin : g_held
                        logic [W-1:0] arg_q;
                        always_ff @(posedge clk) begin
                            if (accept) begin
                                arg_q <= args[(gr*N_UNITS + gi)*W +: W];
                            end
                        end
                        assign opnd[gr] = arg_q;
                    end
                end else begin : g_idle
                    assign live[gr] = 1'b0;
                    assign opnd[gr] = '0;
                end
            end

            assign isqrt_x_vld[gi]      = issuing & live[rsel];
            assign isqrt_x[gi*W +: W]   = opnd[rsel];
        end
    endgenerate

    always_comb begin
        y_sum = '0;
        y_cnt = '0;
        for (int u = 0; u < N_UNITS; u++) begin
            if (isqrt_y_vld[u]) begin
                y_sum = y_sum + {{(W-HW){1'b0}}, isqrt_y[u*HW +: HW]};
                y_cnt = y_cnt + CW'(1);
            end
        end
    end

    assign count_sum = count_q + y_cnt;
    assign done      = (state_q != S_IDLE) && (count_sum >= CW'(N_ARGS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            round_q   <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            res_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Results arriving while idle are strays and are dropped.
                    if (accept) begin
                        acc_q   <= '0;
                        count_q <= '0;
                        round_q <= RW'(1);
                        state_q <= (ROUNDS > 1) ? S_ISSUE : S_WAIT;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    acc_q   <= acc_q + y_sum;
                    count_q <= count_sum;
                    if (state_q == S_ISSUE) begin
                        if (round_q == RW'(ROUNDS - 1)) begin
                            state_q <= S_WAIT;
                        end else begin
                            round_q <= round_q + RW'(1);
                        end
                    end
                    if (done) begin
                        state_q   <= S_IDLE;
                        res_q     <= acc_q + y_sum;
                        res_vld_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign res     = res_q;
    assign res_vld = res_vld_q;

endmodule

// File: tb/tb_isqrt_sum_distributor.sv
// Bench for isqrt_sum_distributor: three configurations (3/2, 5/2, 2/4) driven against
// behavioural isqrt unit models with per-unit latency and a plain-arithmetic reference.
module tb_isqrt_sum_distributor;

    typedef logic [31:0] vec_t [5];
    typedef int          lat_t [4];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // configuration 0: N_ARGS=3, N_UNITS=2
    logic a_vld, a_rdy, a_res_vld;
    logic [95:0]  a_args;
    logic [31:0]  a_res;
    logic [1:0]   a_xv, a_yv;
    logic [63:0]  a_x;
    logic [31:0]  a_y;
    // configuration 1: N_ARGS=5, N_UNITS=2
    logic b_vld, b_rdy, b_res_vld;
    logic [159:0] b_args;
    logic [31:0]  b_res;
    logic [1:0]   b_xv, b_yv;
    logic [63:0]  b_x;
    logic [31:0]  b_y;
    // configuration 2: N_ARGS=2, N_UNITS=4
    logic c_vld, c_rdy, c_res_vld;
    logic [63:0]  c_args;
    logic [31:0]  c_res;
    logic [3:0]   c_xv, c_yv;
    logic [127:0] c_x;
    logic [63:0]  c_y;

    isqrt_sum_distributor #(.N_ARGS(3), .N_UNITS(2), .W(32)) dut_a (
        .clk(clk), .rst(rst), .arg_vld(a_vld), .arg_rdy(a_rdy), .args(a_args),
        .res_vld(a_res_vld), .res(a_res), .isqrt_x_vld(a_xv), .isqrt_x(a_x),
        .isqrt_y_vld(a_yv), .isqrt_y(a_y));
    isqrt_sum_distributor #(.N_ARGS(5), .N_UNITS(2), .W(32)) dut_b (
        .clk(clk), .rst(rst), .arg_vld(b_vld), .arg_rdy(b_rdy), .args(b_args),
        .res_vld(b_res_vld), .res(b_res), .isqrt_x_vld(b_xv), .isqrt_x(b_x),
        .isqrt_y_vld(b_yv), .isqrt_y(b_y));
    isqrt_sum_distributor #(.N_ARGS(2), .N_UNITS(4), .W(32)) dut_c (
        .clk(clk), .rst(rst), .arg_vld(c_vld), .arg_rdy(c_rdy), .args(c_args),
        .res_vld(c_res_vld), .res(c_res), .isqrt_x_vld(c_xv), .isqrt_x(c_x),
        .isqrt_y_vld(c_yv), .isqrt_y(c_y));

    int vectors;
    int miscompares;
    int cyc_cnt = 0;
    logic stray = 1'b0;

    logic        pv   [3][4][16];
    logic [15:0] pd   [3][4][16];
    int          lat  [3][4];
    logic [3:0]  yv_m [3];
    logic [15:0] yd_m [3][4];

    assign a_yv = yv_m[0][1:0];
    assign a_y  = {yd_m[0][1], yd_m[0][0]};
    assign b_yv = yv_m[1][1:0];
    assign b_y  = {yd_m[1][1], yd_m[1][0]};
    assign c_yv = yv_m[2];
    assign c_y  = {yd_m[2][3], yd_m[2][2], yd_m[2][1], yd_m[2][0]};

    function automatic int nargs(input int i);
        return (i == 1) ? 5 : (i == 2) ? 2 : 3;
    endfunction
    function automatic int nunits(input int i);
        return (i == 2) ? 4 : 2;
    endfunction
    function automatic logic get_rdy(input int i);
        return (i == 0) ? a_rdy : (i == 1) ? b_rdy : c_rdy;
    endfunction
    function automatic logic get_res_vld(input int i);
        return (i == 0) ? a_res_vld : (i == 1) ? b_res_vld : c_res_vld;
    endfunction
    function automatic logic [31:0] get_res(input int i);
        return (i == 0) ? a_res : (i == 1) ? b_res : c_res;
    endfunction
    function automatic logic [3:0] get_xv(input int i);
        return (i == 0) ? {2'b00, a_xv} : (i == 1) ? {2'b00, b_xv} : c_xv;
    endfunction
    function automatic logic [31:0] get_x(input int i, input int u);
        if (i == 0) return a_x[u*32 +: 32];
        if (i == 1) return b_x[u*32 +: 32];
        return c_x[u*32 +: 32];
    endfunction

    function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
        longint r = 0;
        longint c;
        for (int b = 15; b >= 0; b--) begin
            c = r | (longint'(1) << b);
            if (c * c <= longint'({32'b0, x})) r = c;
        end
        return 16'(r);
    endfunction

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // isqrt unit models: each issue reappears lat cycles later as a result strobe
    always @(negedge clk) begin
        int s;
        s = cyc_cnt % 16;
        for (int i = 0; i < 3; i++) begin
            for (int u = 0; u < 4; u++) begin
                logic [3:0] xv;
                int s2;
                if (rst) begin
                    yv_m[i][u] = 1'b0;
                    yd_m[i][u] = 16'h0;
                    for (int k = 0; k < 16; k++) pv[i][u][k] = 1'b0;
                end else begin
                    yv_m[i][u] = pv[i][u][s];
                    yd_m[i][u] = pd[i][u][s];
                    pv[i][u][s] = 1'b0;
                    xv = get_xv(i);
                    if (u < nunits(i) && xv[u]) begin
                        s2 = (cyc_cnt + lat[i][u]) % 16;
                        pv[i][u][s2] = 1'b1;
                        pd[i][u][s2] = isqrt_ref(get_x(i, u));
                    end
                end
            end
        end
        if (stray && !rst) begin
            yv_m[0] = 4'b0011;
            yd_m[0][0] = 16'hFFFF;
            yd_m[0][1] = 16'h1234;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
        $display("check %-22s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_in(input int i, input logic vld, input vec_t v);
        case (i)
            0: begin a_vld = vld; a_args = {v[2], v[1], v[0]}; end
            1: begin b_vld = vld; b_args = {v[4], v[3], v[2], v[1], v[0]}; end
            default: begin c_vld = vld; c_args = {v[1], v[0]}; end
        endcase
    endtask

    task automatic check_round(input int i, input int r, input vec_t v);
        logic [3:0] xv;
        int idx;
        xv = get_xv(i);
        for (int u = 0; u < nunits(i); u++) begin
            idx = r * nunits(i) + u;
            chk($sformatf("issue_vld c%0d r%0d u%0d", i, r, u), 64'(xv[u]), 64'(idx < nargs(i)));
            if (idx < nargs(i))
                chk($sformatf("issue_x c%0d r%0d u%0d", i, r, u), 64'(get_x(i, u)), 64'(v[idx]));
        end
    endtask

    // One operation on configuration i; pre: already at the accept cycle; chain: offer nv next.
    task automatic run_op(input int i, input vec_t v, input lat_t l, input bit pre,
                          input bit chain, input vec_t nv);
        int na, nu, rounds, cyc, n, exp_lat;
        logic [31:0] exp_res;
        logic done, extra;
        na = nargs(i);
        nu = nunits(i);
        rounds = (na + nu - 1) / nu;
        exp_res = 0;
        exp_lat = 0;
        for (int k = 0; k < na; k++) begin
            exp_res = exp_res + {16'h0, isqrt_ref(v[k])};
            if (k / nu + l[k % nu] > exp_lat) exp_lat = k / nu + l[k % nu];
        end
        exp_lat = exp_lat + 1;
        if (!pre) begin
            @(posedge clk); #1;
            for (int u = 0; u < 4; u++) lat[i][u] = l[u];
            set_in(i, 1'b1, v);
            n = 0;
            @(negedge clk);
            while (!get_rdy(i) && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rdy_at_accept", 64'(get_rdy(i)), 64'(1));
        check_round(i, 0, v);
        cyc = 0;
        done = 1'b0;
        extra = 1'b0;
        while (!done && cyc < 60) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                if (chain) set_in(i, 1'b1, nv);
                else set_in(i, 1'b0, v);
            end
            cyc++;
            @(negedge clk);
            if (cyc == 1) chk("rdy_busy", 64'(get_rdy(i)), 64'(0));
            if (cyc < rounds) check_round(i, cyc, v);
            if (get_res_vld(i)) done = 1'b1;
            else if (cyc >= rounds && get_xv(i) != 4'b0) extra = 1'b1;
        end
        chk("res_vld_seen", 64'(done), 64'(1));
        chk("latency", 64'(cyc), 64'(exp_lat));
        chk("res", 64'(get_res(i)), 64'(exp_res));
        chk("no_extra_issue", 64'(extra), 64'(0));
        if (!chain) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("res_vld_pulse", 64'(get_res_vld(i)), 64'(0));
            chk("res_hold", 64'(get_res(i)), 64'(exp_res));
            chk("rdy_after", 64'(get_rdy(i)), 64'(1));
        end
    endtask

    initial begin
        vec_t v1, v2;
        lat_t lt;
        logic seen;
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 3; i++) for (int u = 0; u < 4; u++) lat[i][u] = 1;
        v1 = '{0, 0, 0, 0, 0};
        for (int i = 0; i < 3; i++) set_in(i, 1'b0, v1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_rdy", 64'(get_rdy(i)), 64'(1));
            chk("reset_res_vld", 64'(get_res_vld(i)), 64'(0));
            chk("reset_res", 64'(get_res(i)), 64'(0));
            chk("reset_x_vld", 64'(get_xv(i)), 64'(0));
        end

        v1 = '{16, 9, 4, 0, 0};           lt = '{1, 1, 1, 1};
        run_op(0, v1, lt, 1'b0, 1'b0, v1);
        v1 = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0}; lt = '{3, 3, 3, 3};
        run_op(0, v1, lt, 1'b0, 1'b0, v1);

        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        v1 = '{25, 36, 49, 0, 0};         lt = '{2, 2, 2, 2};
        run_op(0, v1, lt, 1'b0, 1'b0, v1);

        v1 = '{0, 1, 4, 0, 0};
        v2 = '{100, 144, 225, 0, 0};
        run_op(0, v1, lt, 1'b0, 1'b1, v2);
        run_op(0, v2, lt, 1'b1, 1'b0, v2);

        v1 = '{1, 1, 1, 0, 0};            lt = '{2, 7, 1, 1};
        run_op(0, v1, lt, 1'b0, 1'b0, v1);

        v1 = '{1, 4, 9, 16, 25};          lt = '{2, 2, 2, 2};
        run_op(1, v1, lt, 1'b0, 1'b0, v1);
        v1 = '{49, 64, 0, 0, 0};          lt = '{1, 1, 1, 1};
        run_op(2, v1, lt, 1'b0, 1'b0, v1);

        // reset while waiting on slow results
        v1 = '{1, 1, 1, 0, 0};
        @(posedge clk); #1;
        lat[0][0] = 7; lat[0][1] = 7;
        set_in(0, 1'b1, v1);
        @(negedge clk);
        chk("mr_accept", 64'(a_rdy), 64'(1));
        @(posedge clk); #1 set_in(0, 1'b0, v1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mr_rdy", 64'(a_rdy), 64'(1));
        chk("mr_res_vld", 64'(a_res_vld), 64'(0));
        chk("mr_res", 64'(a_res), 64'(0));
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (a_res_vld) seen = 1'b1;
        end
        chk("mr_no_res_vld", 64'(seen), 64'(0));
        v1 = '{9, 16, 25, 0, 0};          lt = '{3, 3, 3, 3};
        run_op(0, v1, lt, 1'b0, 1'b0, v1);

        for (int t = 0; t < 24; t++) begin
            int i;
            i = t % 3;
            for (int k = 0; k < 5; k++)
                v1[k] = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 2000));
            for (int u = 0; u < 4; u++) lt[u] = $urandom_range(1, 8);
            run_op(i, v1, lt, 1'b0, 1'b0, v1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
